// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states and default sizes.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/addsub_nbit.sv
// Ripple-carry adder/subtractor: i_mode=1 inverts i_B and injects carry-in.
module addsub_nbit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH-1:0] b_x;
    logic             carry;

    always_comb begin
        b_x   = i_B ^ {WIDTH{i_mode}};
        carry = i_mode;
        o_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_A[i] ^ b_x[i] ^ carry;
            carry    = (i_A[i] & b_x[i]) | (carry & (i_A[i] ^ b_x[i]));
        end
        o_carry = carry;
    end

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
module div_restoring_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             take;

    // P stays below the divisor, so its (WIDTH+1)th bit is always zero
    // and is not stored; the same bound keeps diff[WIDTH] clear on a take.
    assign trial = {p_q, q_q[WIDTH-1]};
    assign take  = no_borrow & ~diff[WIDTH];

    addsub_nbit #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .i_A     (trial),
        .i_B     ({1'b0, dvs_q}),
        .i_mode  (1'b1),
        .o_sum   (diff),
        .o_carry (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    dvs_d = i_divisor;
                    if (i_divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = i_dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        p_d     = '0;
                        q_d     = i_dividend;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                p_d   = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], take};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = p_d;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_busy        = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign o_done        = (state_q == ST_DONE);
    assign o_quotient    = quot_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Directed-vector and sweep bench for the sequential restoring divider.
module tb_div_restoring_seq;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic [3:0] i_dividend;
    logic [3:0] i_divisor;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_quotient;
    logic [3:0] o_remainder;
    logic       o_div_by_zero;

    int checks = 0;
    int fails  = 0;

    always #5 i_clk = ~i_clk;

    div_restoring_seq #(.WIDTH(4)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    typedef struct {
        logic [3:0] dvd;
        logic [3:0] dvs;
        logic [3:0] quo;
        logic [3:0] rem;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Pulse start, wait for done (bounded), return latency and whether busy held.
    task automatic launch(input logic [3:0] dvd, input logic [3:0] dvs,
                          output int lat, output bit busy_ok);
        i_dividend = dvd;
        i_divisor  = dvs;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!o_done && lat < 20) begin
            if (!o_busy) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (!o_busy) busy_ok = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] dvd,
                           input logic [3:0] dvs, input logic [3:0] quo,
                           input logic [3:0] rem, input logic dbz,
                           input int exp_lat);
        int lat;
        bit busy_ok;
        launch(dvd, dvs, lat, busy_ok);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " quotient"}, int'(o_quotient), int'(quo));
        chk({tag, " remainder"}, int'(o_remainder), int'(rem));
        chk({tag, " div_by_zero"}, int'(o_div_by_zero), int'(dbz));
        step();
        chk({tag, " done pulse width"}, int'(o_done), 0);
    endtask

    initial begin
        int lat;
        bit busy_ok;
        int dones;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4};
        vecs[2] = '{4'd2,  4'd7,  4'd0,  4'd2, 1'b0, 4};
        vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4};
        vecs[4] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 0};
        vecs[5] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, 4};
        vecs[6] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 4};
        vecs[7] = '{4'd7,  4'd2,  4'd3,  4'd1, 1'b0, 4};
        vecs[8] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 0};

        i_reset    = 1'b1;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        step();
        step();
        i_reset = 1'b0;
        chk("reset busy", int'(o_busy), 0);
        chk("reset done", int'(o_done), 0);
        chk("reset quotient", int'(o_quotient), 0);
        chk("reset remainder", int'(o_remainder), 0);
        chk("reset div_by_zero", int'(o_div_by_zero), 0);

        launch(4'd13, 4'd3, lat, busy_ok);
        chk("13/3 busy through calc", int'(busy_ok), 1);
        chk("13/3 first latency", lat, 4);
        step();
        chk("13/3 busy drops", int'(o_busy), 0);

        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs,
                    vecs[i].quo, vecs[i].rem, vecs[i].dbz, vecs[i].lat);
        end

        // Start during CALC must be ignored.
        i_dividend = 4'd13;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_dividend = 4'd6;
        i_divisor  = 4'd2;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        dones   = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_done) begin
                dones++;
                chk("ignored-start quotient", int'(o_quotient), 4);
                chk("ignored-start remainder", int'(o_remainder), 1);
            end
            step();
        end
        chk("ignored-start done count", dones, 1);

        // Reset mid-CALC wins, including over a start on the same edge.
        i_dividend = 4'd13;
        i_divisor  = 4'd3;
        i_start    = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_reset = 1'b1;
        i_start = 1'b1;
        step();
        i_reset = 1'b0;
        i_start = 1'b0;
        chk("midreset busy", int'(o_busy), 0);
        chk("midreset done", int'(o_done), 0);
        chk("midreset quotient", int'(o_quotient), 0);
        chk("midreset remainder", int'(o_remainder), 0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_done) dones++;
            step();
        end
        chk("midreset no done", dones, 0);
        run_vec("after-reset 7/2", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 4);

        // Full sweep, each start issued in the first idle cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [3:0] eq, er;
                eq = (b == 0) ? 4'hF : 4'(a / b);
                er = (b == 0) ? 4'(a) : 4'(a % b);
                launch(4'(a), 4'(b), lat, busy_ok);
                chk($sformatf("sweep %0d/%0d latency", a, b), lat,
                    (b == 0) ? 0 : 4);
                chk($sformatf("sweep %0d/%0d quotient", a, b),
                    int'(o_quotient), int'(eq));
                chk($sformatf("sweep %0d/%0d remainder", a, b),
                    int'(o_remainder), int'(er));
                chk($sformatf("sweep %0d/%0d div_by_zero", a, b),
                    int'(o_div_by_zero), (b == 0) ? 1 : 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
